vga_frame_grabber: RTL and testbench

- Avalon-MM slave that captures one decimated frame of the 24-bit VGA pixel stream into an internal FIFO, for the HPS card-recognition software to drain.
- Successor to the single-pixel VGA read peripheral. Adds a configurable channel width, a buffered capture depth, pixel decimation, a frame-synchronous arm/capture/done state machine, sticky error flags, a frame counter and an interrupt.
- Sits between the VGA timing/pixel generator and the lightweight HPS-to-FPGA bridge.

---
 rtl/vga_frame_grabber.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_frame_grabber.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_grabber.sv
// vga_frame_grabber: Avalon-MM slave that buffers one decimated VGA frame; luma-only mode with VGA_FRAME_GRABBER_GRAY_EN.
// Latency: a sampled pixel shows in the FIFO level next cycle; readdata is combinational (zero wait states).
// Backpressure: none toward VGA; pixels arriving at a full FIFO are dropped and raise sticky overflow.

module vga_frame_grabber_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign rd_dat = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign do_rd  = rd_rdy & ~empty & ~flush;
  assign do_wr  = wr_vld & (~full | do_rd) & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module vga_frame_grabber #(
  parameter int CHAN_W     = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int SKIP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [7:0]            writedata,
  output logic [3*CHAN_W-1:0]   readdata,
  input  logic [CHAN_W-1:0]     VGA_R,
  input  logic [CHAN_W-1:0]     VGA_G,
  input  logic [CHAN_W-1:0]     VGA_B,
  input  logic                  VGA_BLANK_n,
  input  logic                  HSYNC,
  input  logic                  VSYNC,
  output logic                  get_img,
  output logic                  irq
);
  localparam int DW = 3 * CHAN_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SKIP > 1) ? $clog2(SKIP) : 1;
`ifdef VGA_FRAME_GRABBER_GRAY_EN
  localparam int FW = CHAN_W;
`else
  localparam int FW = DW;
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          vsync_q;
  logic          frame_start;
  logic          frame_end;
  logic [CW-1:0] dec_cnt;
  logic [15:0]   frame_count;
  logic          ovf_flag;
  logic          unf_flag;

  logic          rd_data_sel;
  logic          rd_stat_sel;
  logic          wr_ctrl_sel;
  logic          arm_req;
  logic          abort_req;
  logic          clr_req;
  logic          do_arm;
  logic          flush;
  logic          done_entry;
  logic          active_px;
  logic          push_vld;
  logic          pop_rdy;
  logic          pop_ok;
  logic          ovf_set;
  logic          unf_set;
  logic [FW-1:0] px_dat;
  logic [FW-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          ctrl_unused;

  assign rd_data_sel = chipselect & read  & (address == 2'd0);
  assign rd_stat_sel = chipselect & read  & (address == 2'd1);
  assign wr_ctrl_sel = chipselect & write & (address == 2'd1);
  assign arm_req     = wr_ctrl_sel & writedata[0];
  assign abort_req   = wr_ctrl_sel & writedata[1];
  assign clr_req     = wr_ctrl_sel & writedata[2];
  assign do_arm      = arm_req & ~abort_req & ((state == ST_IDLE) | (state == ST_DONE));
  assign flush       = abort_req | do_arm;

  // Frame starts at the end of the vsync pulse and ends when the next pulse begins.
  assign frame_start = VSYNC & ~vsync_q;
  assign frame_end   = ~VSYNC & vsync_q;
  assign done_entry  = (state == ST_CAPTURE) & frame_end & ~abort_req;

  assign active_px = (state == ST_CAPTURE) & VGA_BLANK_n;
  assign push_vld  = active_px & (dec_cnt == '0) & ~flush;
  assign pop_rdy   = rd_data_sel;
  assign pop_ok    = pop_rdy & ~fifo_empty & ~flush;
  assign ovf_set   = push_vld & fifo_full & ~pop_ok;
  assign unf_set   = pop_rdy & fifo_empty;
  assign get_img   = (state == ST_CAPTURE);

`ifdef VGA_FRAME_GRABBER_GRAY_EN
  logic [CHAN_W+1:0] luma_sum;
  assign luma_sum    = {2'b00, VGA_R} + {1'b0, VGA_G, 1'b0} + {2'b00, VGA_B};
  assign px_dat      = luma_sum[CHAN_W+1:2];
  assign ctrl_unused = ^{writedata[7:3], HSYNC, luma_sum[1:0]};
`else
  assign px_dat      = {VGA_R, VGA_G, VGA_B};
  assign ctrl_unused = ^{writedata[7:3], HSYNC};
`endif

  vga_frame_grabber_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .wr_vld (push_vld),
    .wr_dat (px_dat),
    .rd_rdy (pop_rdy),
    .rd_dat (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm_req)     state_nxt = ST_ARMED;
        ST_ARMED:         if (frame_start) state_nxt = ST_CAPTURE;
        ST_CAPTURE:       if (frame_end)   state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      vsync_q     <= 1'b1;
      dec_cnt     <= '0;
      frame_count <= '0;
      irq         <= 1'b0;
      ovf_flag    <= 1'b0;
      unf_flag    <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_q <= VSYNC;

      if (do_arm) begin
        dec_cnt <= '0;
      end else if (active_px) begin
        dec_cnt <= (dec_cnt == CW'(SKIP - 1)) ? '0 : dec_cnt + CW'(1);
      end

      if (done_entry) frame_count <= frame_count + 16'd1;

      if (flush)                                  irq <= 1'b0;
      else if (done_entry)                        irq <= 1'b1;
      else if (rd_stat_sel && (state == ST_DONE)) irq <= 1'b0;

      // A set event in the same cycle as a clear request keeps the flag set.
      ovf_flag <= ovf_set | (ovf_flag & ~clr_req);
      unf_flag <= unf_set | (unf_flag & ~clr_req);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        if (!fifo_empty) readdata[FW-1:0] = fifo_head;
      end
      2'd1: begin
        readdata[1:0]     = state;
        readdata[2]       = fifo_empty;
        readdata[3]       = fifo_full;
        readdata[4]       = ovf_flag;
        readdata[5]       = unf_flag;
        readdata[6 +: LW] = fifo_level;
      end
      2'd2:    readdata = DW'(frame_count);
      default: readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_vga_frame_grabber.sv
// Bench for vga_frame_grabber: three instances (default, SKIP=3, FIFO_DEPTH=4) share the VGA stream.
// Every cycle goes through one task so each call owns exactly one rising edge.
module tb_vga_frame_grabber;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cs;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [7:0]  writedata;
  logic [23:0] rdata [3];
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_BLANK_n, HSYNC, VSYNC;
  logic [2:0]  get_img;
  logic [2:0]  irq;
  logic        vs_cur;
  logic [23:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_grabber u0 (
    .clk(clk), .reset(reset), .chipselect(cs[0]), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rdata[0]), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_BLANK_n(VGA_BLANK_n), .HSYNC(HSYNC), .VSYNC(VSYNC), .get_img(get_img[0]), .irq(irq[0])
  );

  vga_frame_grabber #(.SKIP(3)) u1 (
    .clk(clk), .reset(reset), .chipselect(cs[1]), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rdata[1]), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_BLANK_n(VGA_BLANK_n), .HSYNC(HSYNC), .VSYNC(VSYNC), .get_img(get_img[1]), .irq(irq[1])
  );

  vga_frame_grabber #(.FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .chipselect(cs[2]), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rdata[2]), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_BLANK_n(VGA_BLANK_n), .HSYNC(HSYNC), .VSYNC(VSYNC), .get_img(get_img[2]), .irq(irq[2])
  );

  function automatic logic [23:0] exp_pix(input logic [23:0] p);
`ifdef VGA_FRAME_GRABBER_GRAY_EN
    logic [9:0] s;
    s = {2'b00, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b00, p[7:0]};
    return {16'h0000, s[9:2]};
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic bl, input logic [23:0] px, input int sel,
                     input logic r, input logic w, input logic [1:0] a, input logic [7:0] wd,
                     output logic [23:0] rdat);
    @(negedge clk);
    VSYNC = vs;
    VGA_BLANK_n = bl;
    {VGA_R, VGA_G, VGA_B} = px;
    cs = (sel >= 0) ? (3'b001 << sel) : 3'b000;
    read = r;
    write = w;
    address = a;
    writedata = wd;
    #1;
    rdat = rdata[(sel >= 0) ? sel : 0];
  endtask

  task automatic pix(input logic bl, input logic [23:0] px);
    logic [23:0] d;
    cyc(vs_cur, bl, px, -1, 1'b0, 1'b0, 2'd0, 8'h00, d);
  endtask

  task automatic idle();
    pix(1'b0, 24'h0);
  endtask

  task automatic vs(input logic v);
    vs_cur = v;
    idle();
  endtask

  task automatic rd(input int sel, input logic [1:0] a, output logic [23:0] d);
    cyc(vs_cur, 1'b0, 24'h0, sel, 1'b1, 1'b0, a, 8'h00, d);
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [7:0] wd);
    logic [23:0] d;
    cyc(vs_cur, 1'b0, 24'h0, sel, 1'b0, 1'b1, a, wd, d);
  endtask

  task automatic frame(input int sel, input int n, input int skip, input int depth);
    int stored;
    logic [23:0] px;
    stored = 0;
    vs(1'b0); vs(1'b0); vs(1'b1);
    idle();
    chk("armed_to_capture", get_img[sel], 1);
    for (int k = 0; k < n; k++) begin
      px = {8'(k + 1), 8'(k + 2), 8'(k + 3)};
      pix(1'b1, px);
      if ((k % skip) == 0 && stored < depth) begin
        sb.push_back(exp_pix(px));
        stored++;
      end
    end
    idle(); idle();
    vs(1'b0);
    idle();
    chk("capture_to_done", get_img[sel], 0);
    vs(1'b1);
  endtask

  task automatic drain(input int sel);
    logic [23:0] d;
    while (sb.size() > 0) begin
      rd(sel, 2'd0, d);
      chk("data_order", d, sb.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] d;
    logic [23:0] px;
    reset = 1'b0; cs = 3'b000; address = 2'd0; read = 1'b0; write = 1'b0; writedata = 8'h00;
    VGA_R = 8'h00; VGA_G = 8'h00; VGA_B = 8'h00; VGA_BLANK_n = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1;
    vs_cur = 1'b1;
    repeat (3) idle();
    reset = 1'b1;

    // Reset in the middle of a capture with five pixels buffered.
    wr(0, 2'd1, 8'h01);
    vs(1'b0); vs(1'b0); vs(1'b1);
    for (int k = 0; k < 5; k++) pix(1'b1, 24'hA00000 + 24'(k));
    idle();
    rd(0, 2'd1, d);
    chk("pre_reset_state", d[1:0], 2);
    chk("pre_reset_level", d[12:6], 5);
    idle();
    reset = 1'b0;
    #1;
    chk("rst_get_img", get_img[0], 0);
    chk("rst_irq", irq[0], 0);
    rd(0, 2'd1, d);
    chk("rst_state", d[1:0], 0);
    chk("rst_level", d[12:6], 0);
    rd(0, 2'd2, d);
    chk("rst_frame_count", d, 0);
    idle();
    reset = 1'b1;
    rd(0, 2'd0, d);
    chk("empty_data", d, 0);
    rd(0, 2'd1, d);
    chk("underflow_set", d[5], 1);
    chk("empty_flag", d[2], 1);

    // Basic capture of ten pixels.
    wr(0, 2'd1, 8'h04);
    wr(0, 2'd1, 8'h01);
    rd(0, 2'd1, d);
    chk("armed_state", d[1:0], 1);
    chk("flags_cleared", d[5:4], 0);
    frame(0, 10, 1, 64);
    chk("irq_set", irq[0], 1);
    rd(0, 2'd1, d);
    chk("done_state", d[1:0], 3);
    chk("done_level", d[12:6], 10);
    idle();
    chk("irq_cleared_by_status", irq[0], 0);
    rd(0, 2'd2, d);
    chk("frame_count_1", d, 1);
    rd(0, 2'd3, d);
    chk("addr3_zero", d, 0);
    drain(0);
    rd(0, 2'd0, d);
    chk("data_past_end", d, 0);
    rd(0, 2'd1, d);
    chk("underflow_after_drain", d[5], 1);
    chk("level_after_drain", d[12:6], 0);

    // Arm during capture is ignored; deselected write is ignored; arm+abort aborts.
    wr(0, 2'd1, 8'h04);
    wr(0, 2'd1, 8'h01);
    vs(1'b0); vs(1'b0); vs(1'b1);
    for (int k = 0; k < 3; k++) pix(1'b1, 24'h300000 + 24'(k));
    idle();
    wr(0, 2'd1, 8'h01);
    rd(0, 2'd1, d);
    chk("arm_in_capture_state", d[1:0], 2);
    chk("arm_in_capture_level", d[12:6], 3);
    cyc(vs_cur, 1'b0, 24'h0, -1, 1'b0, 1'b1, 2'd1, 8'h02, d);
    rd(0, 2'd1, d);
    chk("no_cs_no_abort", d[1:0], 2);
    wr(0, 2'd1, 8'h03);
    rd(0, 2'd1, d);
    chk("abort_state", d[1:0], 0);
    chk("abort_empty", d[2], 1);
    chk("abort_level", d[12:6], 0);
    chk("abort_get_img", get_img[0], 0);

    // Pixel packing (RGB or luma).
    wr(0, 2'd1, 8'h01);
    vs(1'b0); vs(1'b0); vs(1'b1);
    pix(1'b1, 24'h4080C0);
    idle();
    vs(1'b0); idle(); vs(1'b1);
    rd(0, 2'd0, d);
`ifdef VGA_FRAME_GRABBER_GRAY_EN
    chk("pixel_format", d, 24'h000080);
`else
    chk("pixel_format", d, 24'h4080C0);
`endif

    // Decimation by three.
    wr(1, 2'd1, 8'h01);
    frame(1, 9, 3, 64);
    rd(1, 2'd1, d);
    chk("skip3_state", d[1:0], 3);
    chk("skip3_level", d[12:6], 3);
    drain(1);

    // Overflow on a four-entry FIFO.
    wr(2, 2'd1, 8'h01);
    frame(2, 6, 1, 4);
    rd(2, 2'd1, d);
    chk("ovf_level", d[8:6], 4);
    chk("ovf_full", d[3], 1);
    chk("ovf_flag", d[4], 1);
    wr(2, 2'd1, 8'h04);
    rd(2, 2'd1, d);
    chk("ovf_cleared", d[4], 0);
    chk("ovf_level_kept", d[8:6], 4);
    drain(2);

    // Pop and push in the same cycle on a full FIFO.
    wr(2, 2'd1, 8'h01);
    vs(1'b0); vs(1'b0); vs(1'b1);
    for (int k = 0; k < 4; k++) begin
      px = {8'h70 + 8'(k), 8'h11, 8'h22};
      pix(1'b1, px);
      sb.push_back(exp_pix(px));
    end
    cyc(vs_cur, 1'b1, 24'h55AA33, 2, 1'b1, 1'b0, 2'd0, 8'h00, d);
    chk("pop_while_full", d, sb.pop_front());
    sb.push_back(exp_pix(24'h55AA33));
    idle();
    rd(2, 2'd1, d);
    chk("full_pop_push_level", d[8:6], 4);
    chk("full_pop_push_no_ovf", d[4], 0);
    drain(2);
    wr(2, 2'd1, 8'h02);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
